mem_access_ctrl: RTL and testbench

- Sequential access controller directly upstream of the 32x8 data memory. It is the only block that drives the memory's address, data_in and write pins.
- Accepts single read, single write and wrapping burst-read requests from the CPU datapath over a valid/ready request channel.
- Returns read data or a write acknowledge over a valid/ready response channel.
- Sequences the memory's level-sensitive write strobe so that address and data are stable for one cycle before, during and after the write pulse.

---
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequential access controller for a 32x8 data memory
module mem_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    W_SETUP = 3'd2,
    W_PULSE = 3'd3,
    W_HOLD  = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  // remaining beats after the current one; zero for every non-burst op
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // mem_address doubles as the current transaction address
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_write_q, mem_write_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_last_q, resp_last_d;
  logic              resp_err_q, resp_err_d;

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_last   = resp_last_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_write   = mem_write_q;

  // next-state and registered-output computation for the access sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    mem_write_d   = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_last_d   = resp_last_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = (req_op == 2'b10) ? req_len : '0;
          case (req_op)
            2'b00, 2'b10: begin
              mem_address_d = req_addr;
              state_d       = RD;
            end
            2'b01: begin
              mem_address_d = req_addr;
              mem_data_in_d = req_wdata;
              state_d       = W_SETUP;
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_data_d  = '0;
              resp_last_d  = 1'b1;
              resp_err_d   = 1'b1;
              state_d      = RESP;
            end
          endcase
        end
      end
      RD: begin
        resp_valid_d = 1'b1;
        resp_data_d  = mem_data_out;
        resp_last_d  = (cnt_q == '0);
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      W_SETUP: begin
        mem_write_d = 1'b1;
        state_d     = W_PULSE;
      end
      W_PULSE: begin
        state_d = W_HOLD;
      end
      W_HOLD: begin
        resp_valid_d = 1'b1;
        resp_data_d  = mem_data_in_q;
        resp_last_d  = 1'b1;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d         = cnt_q - ADDR_W'(1);
            mem_address_d = mem_address_q + ADDR_W'(1);
            state_d       = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_write_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_last_q   <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_write_q   <= mem_write_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_last_q   <= resp_last_d;
      resp_err_q    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic [4:0] req_len = 5'd0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic       resp_last;
  logic       resp_err;
  logic [4:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic preload = 1'b1;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];

  mem_access_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:       return 8'h00;
      1:       return 8'hD2;
      5:       return 8'h12;
      30:      return 8'h72;
      31:      return 8'h0B;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // memory model: combinational read, write while mem_write is high at an edge
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (mem_write) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  always @(negedge clk) if (mem_write) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one complete transaction; expectations come from ref_mem, not the DUT
  task automatic run_txn(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wdata,
                         input logic [4:0] len, input int hold,
                         output logic [7:0] first_data, output logic first_err);
    logic [7:0] exp_q [$];
    logic       exp_err;
    int         lat, wr0, exp_lat;
    logic       busy_ok, wr_ok, stable_ok;
    logic [7:0] d0;
    logic       l0, e0;
    exp_q.delete();
    case (op)
      2'b00: exp_q.push_back(ref_mem[addr]);
      2'b01: begin exp_q.push_back(wdata); ref_mem[addr] = wdata; end
      2'b10: for (int i = 0; i <= int'(len); i++) exp_q.push_back(ref_mem[5'(int'(addr) + i)]);
      default: exp_q.push_back(8'h00);
    endcase
    exp_err = (op == 2'b11);
    exp_lat = (op == 2'b01) ? 4 : (op == 2'b11) ? 1 : 2;
    first_data = 8'h00;
    first_err = 1'b0;
    busy_ok = 1'b1;
    wr_ok = 1'b1;
    stable_ok = 1'b1;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_len = len;
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    chk("req_ready_before_accept", int'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom); req_len = 5'($urandom);
    for (int b = 0; b < exp_q.size(); b++) begin
      lat = 1;
      while (!resp_valid && lat < 20) begin
        if (req_ready) busy_ok = 1'b0;
        if (op == 2'b01 && (mem_address !== addr || mem_data_in !== wdata || mem_write !== (lat == 2)))
          wr_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
      chk("resp_valid", int'(resp_valid), 1);
      chk("beat_latency", lat, (b == 0) ? exp_lat : 2);
      if (req_ready) busy_ok = 1'b0;
      chk("resp_data", int'(resp_data), int'(exp_q[b]));
      chk("resp_last", int'(resp_last), (b == exp_q.size() - 1) ? 1 : 0);
      chk("resp_err", int'(resp_err), int'(exp_err));
      if (b == 0) begin first_data = resp_data; first_err = resp_err; end
      d0 = resp_data; l0 = resp_last; e0 = resp_err;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!resp_valid || resp_data !== d0 || resp_last !== l0 || resp_err !== e0 || req_ready)
          stable_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
    end
    chk("req_ready_after", int'(req_ready), 1);
    chk("resp_valid_after", int'(resp_valid), 0);
    chk("req_ready_busy", int'(busy_ok), 1);
    chk("write_pulses", wr_cnt - wr0, (op == 2'b01) ? 1 : 0);
    if (op == 2'b01) chk("write_stable", int'(wr_ok), 1);
    if (hold > 0) chk("backpressure_stable", int'(stable_ok), 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [4:0] len;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       e;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    vecs[0] = '{2'b00, 5'd1,  8'h00, 5'd0, 0, 8'hD2, 1'b0};
    vecs[1] = '{2'b10, 5'd30, 8'h00, 5'd3, 0, 8'h72, 1'b0};
    vecs[2] = '{2'b01, 5'd1,  8'h08, 5'd0, 0, 8'h08, 1'b0};
    vecs[3] = '{2'b00, 5'd1,  8'h00, 5'd0, 0, 8'h08, 1'b0};
    vecs[4] = '{2'b00, 5'd31, 8'h00, 5'd0, 3, 8'h0B, 1'b0};
    vecs[5] = '{2'b11, 5'd5,  8'h00, 5'd0, 0, 8'h00, 1'b1};
    vecs[6] = '{2'b00, 5'd5,  8'h00, 5'd0, 0, 8'h12, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_data", int'(resp_data), 0);
    chk("rst_resp_last", int'(resp_last), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_mem_address", int'(mem_address), 0);
    chk("rst_mem_data_in", int'(mem_data_in), 0);
    chk("rst_mem_write", int'(mem_write), 0);
    reset = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);

    // directed table
    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].len, vecs[v].hold, d, e);
      chk($sformatf("vec%0d_data", v), int'(d), int'(vecs[v].exp_data));
      chk($sformatf("vec%0d_err", v), int'(e), int'(vecs[v].exp_err));
    end

    // reset during the second beat of a 4-beat burst
    req_valid = 1'b1; req_op = 2'b10; req_addr = 5'd0; req_len = 5'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("abort_beat1_valid", int'(resp_valid), 1);
    @(negedge clk);
    resp_ready = 1'b0;
    @(negedge clk);
    chk("abort_beat2_valid", int'(resp_valid), 1);
    chk("abort_beat2_data", int'(resp_data), int'(ref_mem[1]));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_resp_valid", int'(resp_valid), 0);
    chk("abort_mem_write", int'(mem_write), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", int'(req_ready), 1);
    run_txn(2'b00, 5'd0, 8'h00, 5'd0, 0, d, e);
    chk("abort_fresh_read", int'(d), 8'h00);

    // randomized transactions against the reference memory
    for (int t = 0; t < 40; t++) begin
      run_txn(2'($urandom), 5'($urandom), 8'($urandom), 5'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
